interrupt_control_mc: RTL

//  Multi-channel successor of the single-source interrupt controller. Sits between the

---
 rtl/interrupt_control_mc_pkg.sv | 29 ++
 rtl/interrupt_control_mc_if.sv | 32 +++
 rtl/interrupt_control_mc_arbiter.sv | 35 +++
 rtl/interrupt_control_mc.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_control_mc_pkg.sv
// Shared types and helpers for the multi-channel interrupt controller.
//   state_t      : dispatch FSM states
//   irq_level_t  : 2-bit priority level, 3 = highest
//   irq_num_t    : 7-bit IRQ number handed to the exception manager
//   ext_to_entry : ICT entry / IRQ number belonging to an external channel
`ifndef IRQ_NUM_INVALID_VECT
`define IRQ_NUM_INVALID_VECT 7'h7F
`endif

package interrupt_control_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  typedef logic [1:0] irq_level_t;
  typedef logic [6:0] irq_num_t;

  localparam irq_num_t   IRQ_NUM_INVALID_VECT = `IRQ_NUM_INVALID_VECT;
  localparam irq_level_t IRQ_LEVEL_MAX        = 2'd3;
  localparam int         PSR_IE_BIT           = 2;

  // External channel c lives at ICT entry ext_base + c; the same value is its IRQ number.
  function automatic irq_num_t ext_to_entry(input int ext_base, input int ch);
    return irq_num_t'(ext_base + ch);
  endfunction

endpackage

// File: rtl/interrupt_control_mc_if.sv
// Handshake between the interrupt controller and the core exception manager.
//   exception_lock     : manager busy, no new dispatch
//   exception_active   : an IRQ is offered
//   exception_irq_num  : number of the offered IRQ
//   exception_irq_fi0r : fault info (original vector of an invalid-vector IRQ)
//   exception_irq_ack  : manager accepted the offered IRQ
// master = interrupt controller, slave = exception manager.
interface interrupt_control_mc_if;
  import interrupt_control_pkg::*;

  logic        exception_lock;
  logic        exception_active;
  irq_num_t    exception_irq_num;
  logic [31:0] exception_irq_fi0r;
  logic        exception_irq_ack;

  modport master (
    input  exception_lock,
    input  exception_irq_ack,
    output exception_active,
    output exception_irq_num,
    output exception_irq_fi0r
  );

  modport slave (
    output exception_lock,
    output exception_irq_ack,
    input  exception_active,
    input  exception_irq_num,
    input  exception_irq_fi0r
  );
endinterface

// File: rtl/interrupt_control_mc_arbiter.sv
// Combinational winner selection among eligible channels.
//   eligible  : per-channel candidate flags
//   level     : per-channel effective priority level
//   win_valid : at least one candidate
//   win_idx   : highest level wins, ties go to the lowest channel index
module interrupt_priority_arbiter
  import interrupt_control_pkg::*;
#(
  parameter  int P_CHANNELS = 8,
  localparam int IDX_W      = (P_CHANNELS > 1) ? $clog2(P_CHANNELS) : 1
) (
  input  logic [P_CHANNELS-1:0] eligible,
  input  irq_level_t            level [P_CHANNELS],
  output logic                  win_valid,
  output logic [IDX_W-1:0]      win_idx
);

  irq_level_t best_s;
  logic       take_s;

  // Scan from the top index down; '>=' lets a lower index take over on equal level.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    best_s    = 2'd0;
    take_s    = 1'b0;
    for (int c = P_CHANNELS - 1; c >= 0; c--) begin
      take_s    = eligible[c] && (!win_valid || (level[c] >= best_s));
      win_valid = win_valid | take_s;
      win_idx   = take_s ? IDX_W'(c) : win_idx;
      best_s    = take_s ? level[c] : best_s;
    end
  end

endmodule

// File: rtl/interrupt_control_mc.sv
// Multi-channel interrupt controller: pending bits, ICT gating, arbitration and
// request/ack dispatch to the exception manager.
//   iCLOCK / iRESET / iRESET_SYNC : clock, async reset, synchronous clear
//   iICT_*                        : ICT write port (valid, mask, level per entry)
//   iSYSREGINFO_PSR               : PSR, bit 2 is the global interrupt enable
//   iIRQ_THRESHOLD                : minimum level of a normal IRQ
//   iSWI_VALID / iSWI_NUM         : software interrupt request
//   iEXT_REQ / oEXT_ACK           : external level requests and 1-cycle acks
//   exc                           : exception manager handshake (master side)
module interrupt_control_mc
  import interrupt_control_pkg::*;
#(
  parameter  int P_CHANNELS    = 8,
  parameter  int P_ICT_ENTRIES = 64,
  parameter  int P_EXT_BASE    = 4,
  localparam int ENTRY_W       = (P_ICT_ENTRIES > 1) ? $clog2(P_ICT_ENTRIES) : 1,
  localparam int IDX_W         = (P_CHANNELS > 1) ? $clog2(P_CHANNELS) : 1
) (
  input  logic                  iCLOCK,
  input  logic                  iRESET,
  input  logic                  iRESET_SYNC,
  input  logic                  iICT_VALID,
  input  logic [ENTRY_W-1:0]    iICT_ENTRY,
  input  logic                  iICT_CONF_MASK,
  input  logic                  iICT_CONF_VALID,
  input  irq_level_t            iICT_CONF_LEVEL,
  input  logic [31:0]           iSYSREGINFO_PSR,
  input  irq_level_t            iIRQ_THRESHOLD,
  input  logic                  iSWI_VALID,
  input  irq_num_t              iSWI_NUM,
  input  logic [P_CHANNELS-1:0] iEXT_REQ,
  output logic [P_CHANNELS-1:0] oEXT_ACK,
  interrupt_control_mc_if.master exc
);

  state_t                          state_r;
  logic [P_CHANNELS-1:0]           pend_r;
  logic                            swi_latched_r;
  irq_num_t                        swi_num_r;
  logic [P_CHANNELS-1:0]           ict_valid_r;
  logic [P_CHANNELS-1:0]           ict_mask_r;
  irq_level_t [P_CHANNELS-1:0]     ict_level_r;
  logic [P_CHANNELS-1:0]           ext_ack_r;
  logic                            active_r;
  irq_num_t                        irq_num_r;
  logic [31:0]                     irq_fi0r_r;

  logic [P_CHANNELS-1:0]           ict_hit_s;
  logic [P_CHANNELS-1:0]           normal_s;
  logic [P_CHANNELS-1:0]           invalid_s;
  logic [P_CHANNELS-1:0]           eligible_s;
  logic [P_CHANNELS-1:0]           clr_mask_s;
  irq_level_t                      eff_level_s [P_CHANNELS];
  irq_num_t                        chan_num_s  [P_CHANNELS];
  logic                            win_valid_s;
  logic [IDX_W-1:0]                win_idx_s;
  logic                            dispatch_en_s;
  logic                            disp_swi_s;
  logic                            disp_ext_s;
  irq_num_t                        disp_num_s;
  logic [31:0]                     disp_fi0r_s;
  logic                            unused_psr_s;

  assign unused_psr_s = ^{iSYSREGINFO_PSR[31:PSR_IE_BIT+1], iSYSREGINFO_PSR[PSR_IE_BIT-1:0]};

  // Only the entries backing external channels are stored; other indices have no effect.
  for (genvar c = 0; c < P_CHANNELS; c++) begin : g_chan
    localparam int ENTRY = P_EXT_BASE + c;
    assign ict_hit_s[c]   = iICT_VALID && (iICT_ENTRY == ENTRY_W'(ENTRY));
    assign chan_num_s[c]  = ext_to_entry(P_EXT_BASE, c);
    assign normal_s[c]    = pend_r[c] & ict_valid_r[c] & ict_mask_r[c]
                            & (ict_level_r[c] >= iIRQ_THRESHOLD);
    // An entry without a handler still competes, as an invalid-vector IRQ at top level.
    assign invalid_s[c]   = pend_r[c] & ~ict_valid_r[c];
    assign eff_level_s[c] = ict_valid_r[c] ? ict_level_r[c] : IRQ_LEVEL_MAX;
  end

  assign eligible_s = normal_s | invalid_s;

  interrupt_priority_arbiter #(
    .P_CHANNELS (P_CHANNELS)
  ) u_arbiter (
    .eligible  (eligible_s),
    .level     (eff_level_s),
    .win_valid (win_valid_s),
    .win_idx   (win_idx_s)
  );

  // A cycle that sees an ack never dispatches, which forces one idle cycle between IRQs.
  assign dispatch_en_s = iSYSREGINFO_PSR[PSR_IE_BIT] & ~exc.exception_lock
                         & ~exc.exception_irq_ack & (state_r == S_IDLE);

  // Pick SWI or external winner and form the number/fault info to latch.
  always_comb begin
    disp_swi_s  = dispatch_en_s & swi_latched_r;
    disp_ext_s  = dispatch_en_s & ~swi_latched_r & win_valid_s;
    clr_mask_s  = '0;
    disp_num_s  = swi_num_r;
    disp_fi0r_s = 32'd0;
    if (disp_ext_s) begin
      clr_mask_s[win_idx_s] = 1'b1;
      if (invalid_s[win_idx_s]) begin
        disp_num_s  = IRQ_NUM_INVALID_VECT;
        disp_fi0r_s = {25'd0, chan_num_s[win_idx_s]};
      end else begin
        disp_num_s  = chan_num_s[win_idx_s];
      end
    end else begin
      clr_mask_s  = '0;
    end
  end

  // ICT storage; arbitration always sees the values from before a same-cycle write.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      ict_valid_r <= '0;
      ict_mask_r  <= '0;
      ict_level_r <= '0;
    end else if (iRESET_SYNC) begin
      ict_valid_r <= '0;
      ict_mask_r  <= '0;
      ict_level_r <= '0;
    end else begin
      for (int c = 0; c < P_CHANNELS; c++) begin
        if (ict_hit_s[c]) begin
          ict_valid_r[c] <= iICT_CONF_VALID;
          ict_mask_r[c]  <= iICT_CONF_MASK;
          ict_level_r[c] <= iICT_CONF_LEVEL;
        end
      end
    end
  end

  // Pending bits and SWI latch; clearing on dispatch wins over a request still high.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      pend_r        <= '0;
      swi_latched_r <= 1'b0;
      swi_num_r     <= 7'd0;
    end else if (iRESET_SYNC) begin
      pend_r        <= '0;
      swi_latched_r <= 1'b0;
      swi_num_r     <= 7'd0;
    end else begin
      pend_r <= (pend_r | iEXT_REQ) & ~clr_mask_s;
      if (disp_swi_s) begin
        swi_latched_r <= 1'b0;
      end else if (iSWI_VALID && !swi_latched_r) begin
        swi_latched_r <= 1'b1;
        swi_num_r     <= iSWI_NUM;
      end
    end
  end

  // Dispatch FSM with registered handshake outputs and channel ack pulse.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state_r    <= S_IDLE;
      active_r   <= 1'b0;
      irq_num_r  <= 7'd0;
      irq_fi0r_r <= 32'd0;
      ext_ack_r  <= '0;
    end else if (iRESET_SYNC) begin
      state_r    <= S_IDLE;
      active_r   <= 1'b0;
      irq_num_r  <= 7'd0;
      irq_fi0r_r <= 32'd0;
      ext_ack_r  <= '0;
    end else begin
      ext_ack_r <= clr_mask_s;
      case (state_r)
        S_IDLE: begin
          if (disp_swi_s || disp_ext_s) begin
            state_r    <= S_REQ;
            active_r   <= 1'b1;
            irq_num_r  <= disp_num_s;
            irq_fi0r_r <= disp_fi0r_s;
          end
        end
        S_REQ: begin
          if (exc.exception_irq_ack) begin
            state_r  <= S_IDLE;
            active_r <= 1'b0;
          end
        end
        default: begin
          state_r  <= S_IDLE;
          active_r <= 1'b0;
        end
      endcase
    end
  end

  assign oEXT_ACK               = ext_ack_r;
  // ACTIVE falls in the very cycle the manager acks.
  assign exc.exception_active   = active_r & ~exc.exception_irq_ack;
  assign exc.exception_irq_num  = irq_num_r;
  assign exc.exception_irq_fi0r = irq_fi0r_r;

endmodule
